apb_loader: RTL and testbench

- Bus initiator that drives the watermarking register bank: issues single writes, single reads, auto-incrementing burst writes, and the CTRL start write.
- Sits between the host/testbench command stream and the register bank's write_en/addr/data_in/data_out port.
- All bus outputs are registered on posedge clk, so they are stable when the bank samples on negedge clk.

---
 rtl/apb_loader.sv | 196 +++++++++++++++++++
 tb/tb_apb_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_loader.sv
// -----------------------------------------------------------------------------
// apb_loader
//
// Bus initiator for the watermarking register bank. It accepts one command at
// a time and turns it into register-bank bus activity:
//   op 00 : single write of cmd_data to cmd_addr
//   op 01 : single read of cmd_addr, result returned on rsp_data/rsp_valid
//   op 10 : burst write of cmd_len stream words starting at cmd_addr,
//           address auto-incrementing and wrapping at the address width
//   op 11 : start write, cmd_data[0] written to CTRL at address 0
// Every bus output is driven from a register updated on the rising edge, so
// the bank, which samples on the falling edge, always sees stable values.
//
// Ports
//   clk, rst                      clock and asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_addr, cmd_data,
//   cmd_len                       command fields, latched at the handshake
//   strm_valid/strm_ready,
//   strm_data                     burst data stream
//   rsp_valid, rsp_data           read result, one-cycle pulse
//   done                          one-cycle pulse when a command completes
//   busy                          high while a command is in progress
//   bus_write_en, bus_addr,
//   bus_wdata, bus_rdata          register bank port
// -----------------------------------------------------------------------------
module apb_loader #(
    parameter int Amba_Word       = 16,
    parameter int Amba_Addr_Depth = 20,
    parameter int Len_Width       = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [Amba_Addr_Depth-1:0] cmd_addr,
    input  logic [Amba_Word-1:0]       cmd_data,
    input  logic [Len_Width-1:0]       cmd_len,
    input  logic                       strm_valid,
    output logic                       strm_ready,
    input  logic [Amba_Word-1:0]       strm_data,
    output logic                       rsp_valid,
    output logic [Amba_Word-1:0]       rsp_data,
    output logic                       done,
    output logic                       busy,
    output logic                       bus_write_en,
    output logic [Amba_Addr_Depth-1:0] bus_addr,
    output logic [Amba_Word-1:0]       bus_wdata,
    input  logic [Amba_Word-1:0]       bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        BURST,
        FIN
    } state_t;

    localparam logic [Len_Width-1:0]       LenOne  = {{(Len_Width-1){1'b0}}, 1'b1};
    localparam logic [Amba_Addr_Depth-1:0] AddrOne = {{(Amba_Addr_Depth-1){1'b0}}, 1'b1};

    state_t                       r_state;
    logic                         r_cmd_ready;
    logic                         r_strm_ready;
    logic                         r_rsp_valid;
    logic [Amba_Word-1:0]         r_rsp_data;
    logic                         r_done;
    logic                         r_busy;
    logic                         r_bus_write_en;
    logic [Amba_Addr_Depth-1:0]   r_bus_addr;
    logic [Amba_Word-1:0]         r_bus_wdata;
    logic [Amba_Addr_Depth-1:0]   r_addr_cnt;
    logic [Len_Width-1:0]         r_remaining;

    logic                         w_cmd_fire;
    logic                         w_strm_fire;

    assign w_cmd_fire  = cmd_valid && r_cmd_ready;
    assign w_strm_fire = strm_valid && r_strm_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cmd_ready    <= 1'b1;
            r_strm_ready   <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_bus_write_en <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_addr_cnt     <= '0;
            r_remaining    <= '0;
        end else begin
            // Pulses and the write strobe last a single cycle unless re-armed.
            r_done         <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_bus_write_en <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        case (cmd_op)
                            2'b00: begin
                                r_state        <= WR;
                                r_bus_write_en <= 1'b1;
                                r_bus_addr     <= cmd_addr;
                                r_bus_wdata    <= cmd_data;
                            end
                            2'b01: begin
                                r_state    <= RD;
                                r_bus_addr <= cmd_addr;
                            end
                            2'b10: begin
                                r_state      <= BURST;
                                r_addr_cnt   <= cmd_addr;
                                r_remaining  <= cmd_len;
                                r_strm_ready <= (cmd_len != '0);
                            end
                            default: begin
                                // Start: CTRL lives at address 0, only bit 0 matters.
                                r_state        <= WR;
                                r_bus_write_en <= 1'b1;
                                r_bus_addr     <= '0;
                                r_bus_wdata    <= {{(Amba_Word-1){1'b0}}, cmd_data[0]};
                            end
                        endcase
                    end
                end

                RD: begin
                    // bus_addr was presented last cycle; the bank has updated
                    // its data_out on the falling edge in between.
                    r_rsp_data  <= bus_rdata;
                    r_rsp_valid <= 1'b1;
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end

                BURST: begin
                    if (r_remaining == '0) begin
                        // Zero-length burst: complete without touching the bus.
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (w_strm_fire) begin
                        r_bus_write_en <= 1'b1;
                        r_bus_addr     <= r_addr_cnt;
                        r_bus_wdata    <= strm_data;
                        r_addr_cnt     <= r_addr_cnt + AddrOne;
                        r_remaining    <= r_remaining - LenOne;
                        if (r_remaining == LenOne) begin
                            // Close the stream on the same edge as the last
                            // word so no extra word can be taken.
                            r_strm_ready <= 1'b0;
                            r_state      <= FIN;
                        end
                    end
                end

                WR, FIN: begin
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end

                default: begin
                    r_state      <= IDLE;
                    r_cmd_ready  <= 1'b1;
                    r_strm_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign strm_ready   = r_strm_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign done         = r_done;
    assign busy         = r_busy;
    assign bus_write_en = r_bus_write_en;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;

endmodule

// File: tb/tb_apb_loader.sv
// -----------------------------------------------------------------------------
// tb_apb_loader
//
// Directed bench for apb_loader with a behavioural register bank attached.
// Expected bus writes and read responses are queued when a step is driven and
// checked by a falling-edge monitor when the loader produces them.
// -----------------------------------------------------------------------------
module tb_apb_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [19:0] cmd_len;
    logic        strm_valid;
    logic        strm_ready;
    logic [15:0] strm_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        done;
    logic        busy;
    logic        bus_write_en;
    logic [19:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    apb_loader dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .strm_valid   (strm_valid),
        .strm_ready   (strm_ready),
        .strm_data    (strm_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .done         (done),
        .busy         (busy),
        .bus_write_en (bus_write_en),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic done_prev = 1'b0;
    logic rsp_prev = 1'b0;

    logic [35:0] exp_wr[$];     // {addr, data}
    logic [15:0] exp_rsp[$];

    // Behavioural register bank: write on falling edge, data_out follows addr.
    logic [15:0] bank_mem [logic [19:0]];
    logic [15:0] bank_dout = 16'h0000;
    assign bus_rdata = bank_dout;

    function automatic logic [15:0] bank_rd(input logic [19:0] a);
        return bank_mem.exists(a) ? bank_mem[a] : 16'h0000;
    endfunction

    task automatic bank_reset();
        bank_mem.delete();
        bank_mem[20'h00001] = 16'h00FF;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor, scoreboard and bank in one falling-edge process.
    always @(negedge clk) begin
        logic [35:0] e;
        if (bus_write_en) begin
            $display("bus write addr=0x%05h data=0x%04h", bus_addr, bus_wdata);
            chk("write_expected", {31'd0, exp_wr.size() != 0}, 32'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                chk("write_addr", {12'd0, bus_addr}, {12'd0, e[35:16]});
                chk("write_data", {16'd0, bus_wdata}, {16'd0, e[15:0]});
            end
            bank_mem[bus_addr] = bus_wdata;
        end
        bank_dout = bank_rd(bus_addr);
        if (rsp_valid) begin
            $display("read response data=0x%04h", rsp_data);
            chk("rsp_expected", {31'd0, exp_rsp.size() != 0}, 32'd1);
            if (exp_rsp.size() != 0)
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_rsp.pop_front()});
            chk("rsp_single", {31'd0, rsp_prev}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            $display("command done");
            chk("done_single", {31'd0, done_prev}, 32'd0);
        end
        done_prev = done;
        rsp_prev  = rsp_valid;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_strm_ready"}, {31'd0, strm_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_we"}, {31'd0, bus_write_en}, 32'd0);
        chk({tag, "_addr"}, {12'd0, bus_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, bus_wdata}, 32'd0);
    endtask

    // Offer a command and return 1ns after the handshake edge.
    task automatic send_cmd(input logic [1:0] op, input logic [19:0] a,
                            input logic [15:0] d, input logic [19:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_len   = len;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Offer one stream word; after the handshake optionally idle for gap cycles.
    task automatic send_word(input logic [15:0] d, input int gap);
        int n = 0;
        strm_valid = 1'b1;
        strm_data  = d;
        while (!strm_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("strm_ready_wait", {31'd0, strm_ready}, 32'd1);
        @(posedge clk); #1;
        chk("burst_we", {31'd0, bus_write_en}, 32'd1);
        chk("burst_wdata", {16'd0, bus_wdata}, {16'd0, d});
        if (gap > 0) begin
            strm_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
                chk("gap_we", {31'd0, bus_write_en}, 32'd0);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic do_read(input logic [19:0] a, input logic [15:0] exp);
        exp_rsp.push_back(exp);
        send_cmd(2'b01, a, 16'h0000, 20'd0);
        chk("rd_we", {31'd0, bus_write_en}, 32'd0);
        chk("rd_addr", {12'd0, bus_addr}, {12'd0, a});
        chk("rd_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rsp_data", {16'd0, rsp_data}, {16'd0, exp});
        chk("rd_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        chk("rd_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int dc;
        logic [15:0] t;
        logic [15:0] words [4];
        words[0] = 16'h0011; words[1] = 16'h0022;
        words[2] = 16'h0033; words[3] = 16'h0044;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
        strm_valid = 1'b0; strm_data = '0;
        bank_reset();
        #2;
        check_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write.
        exp_wr.push_back({20'h00005, 16'h00C8});
        send_cmd(2'b00, 20'h00005, 16'h00C8, 20'd0);
        chk("wr_we", {31'd0, bus_write_en}, 32'd1);
        chk("wr_addr", {12'd0, bus_addr}, 32'h00005);
        chk("wr_wdata", {16'd0, bus_wdata}, 32'h00C8);
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        chk("wr_done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("wr_we_drop", {31'd0, bus_write_en}, 32'd0);
        chk("wr_done", {31'd0, done}, 32'd1);
        chk("wr_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("wr_busy_drop", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("wr_done_drop", {31'd0, done}, 32'd0);
        do_read(20'h00005, 16'h00C8);

        // Reads after bank reset.
        bank_reset();
        do_read(20'h00001, 16'h00FF);
        do_read(20'h00000, 16'h0000);

        // Burst of four with a two-cycle gap after the second word.
        dc = done_cnt;
        for (int i = 0; i < 4; i++)
            exp_wr.push_back({20'h0000A + 20'(i), words[i]});
        send_cmd(2'b10, 20'h0000A, 16'h0000, 20'd4);
        chk("bu_strm_ready", {31'd0, strm_ready}, 32'd1);
        chk("bu_busy", {31'd0, busy}, 32'd1);
        chk("bu_we_idle", {31'd0, bus_write_en}, 32'd0);
        send_word(words[0], 0);
        send_word(words[1], 2);
        send_word(words[2], 0);
        send_word(words[3], 0);
        chk("bu_last_addr", {12'd0, bus_addr}, 32'h0000D);
        chk("bu_ready_closed", {31'd0, strm_ready}, 32'd0);
        strm_data = 16'h0055;       // fifth word offered, must be ignored
        @(posedge clk); #1;
        chk("bu_done", {31'd0, done}, 32'd1);
        chk("bu_we_end", {31'd0, bus_write_en}, 32'd0);
        @(posedge clk); #1;
        chk("bu_no_extra_we", {31'd0, bus_write_en}, 32'd0);
        chk("bu_strm_ready_idle", {31'd0, strm_ready}, 32'd0);
        strm_valid = 1'b0;
        chk("bu_done_count", 32'(done_cnt - dc), 32'd1);
        for (int i = 0; i < 4; i++)
            chk("bu_bank", {16'd0, bank_rd(20'h0000A + 20'(i))}, {16'd0, words[i]});
        chk("bu_bank_past_end", {16'd0, bank_rd(20'h0000E)}, 32'd0);

        // Address wrap.
        exp_wr.push_back({20'hFFFFF, 16'hAAAA});
        exp_wr.push_back({20'h00000, 16'hBBBB});
        send_cmd(2'b10, 20'hFFFFF, 16'h0000, 20'd2);
        send_word(16'hAAAA, 0);
        chk("wrap_addr0", {12'd0, bus_addr}, 32'hFFFFF);
        send_word(16'hBBBB, 1);
        chk("wrap_addr1", {12'd0, bus_addr}, 32'h00000);
        chk("wrap_done", {31'd0, done}, 32'd1);
        chk("wrap_bank_top", {16'd0, bank_rd(20'hFFFFF)}, 32'hAAAA);
        chk("wrap_bank_zero", {16'd0, bank_rd(20'h00000)}, 32'hBBBB);
        @(posedge clk); #1;

        // Zero-length burst.
        send_cmd(2'b10, 20'h00050, 16'h0000, 20'd0);
        chk("len0_strm_ready", {31'd0, strm_ready}, 32'd0);
        chk("len0_we", {31'd0, bus_write_en}, 32'd0);
        chk("len0_done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_we_end", {31'd0, bus_write_en}, 32'd0);
        chk("len0_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        // Start on and off.
        exp_wr.push_back({20'h00000, 16'h0001});
        send_cmd(2'b11, 20'h00123, 16'h0001, 20'd0);
        chk("start_addr", {12'd0, bus_addr}, 32'h00000);
        chk("start_wdata", {16'd0, bus_wdata}, 32'h0001);
        wait_done("start_done");
        t = bank_rd(20'h00000);
        chk("start_high", {31'd0, t[0]}, 32'd1);
        @(posedge clk); #1;
        exp_wr.push_back({20'h00000, 16'h0000});
        send_cmd(2'b11, 20'h00042, 16'hFFFE, 20'd0);
        chk("stop_wdata", {16'd0, bus_wdata}, 32'h0000);
        wait_done("stop_done");
        t = bank_rd(20'h00000);
        chk("start_low", {31'd0, t[0]}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a four-word burst.
        dc = done_cnt;
        exp_wr.push_back({20'h00100, 16'h0011});
        exp_wr.push_back({20'h00101, 16'h0022});
        send_cmd(2'b10, 20'h00100, 16'h0000, 20'd4);
        send_word(16'h0011, 0);
        send_word(16'h0022, 0);
        strm_valid = 1'b0;
        @(negedge clk); #1;          // second word has reached the bank
        rst = 1'b1;
        #1;
        check_reset_vals("mid");
        @(posedge clk); #1;
        check_reset_vals("mid_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_no_done", 32'(done_cnt - dc), 32'd0);
        chk("mid_bank0", {16'd0, bank_rd(20'h00100)}, 32'h0011);
        chk("mid_bank1", {16'd0, bank_rd(20'h00101)}, 32'h0022);
        chk("mid_bank2", {16'd0, bank_rd(20'h00102)}, 32'h0000);
        chk("mid_bank3", {16'd0, bank_rd(20'h00103)}, 32'h0000);

        // Loader is usable again after reset.
        exp_wr.push_back({20'h00007, 16'h1234});
        send_cmd(2'b00, 20'h00007, 16'h1234, 20'd0);
        wait_done("post_rst_done");
        @(posedge clk); #1;
        chk("post_rst_bank", {16'd0, bank_rd(20'h00007)}, 32'h1234);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
